mem_report_tx: RTL and testbench

Reporting path from the delay-line memory manager to the host UART. Consumes the memory manager's received-number handshake (`mem_received_num` / `mem_received_valid` / `mem_received_replaced` / `mem_received_overrun` / `mem_received_ack`) and serialises each report into a fixed-length byte frame for the UART transmitter. It is the reader of the interface the memory manager writes, and it sits between `mem_manager` and the UART TX byte port.

---
 rtl/mem_report_tx.sv | 138 +++++++++++++
 tb/tb_mem_report_tx.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_report_tx.sv
// mem_report_tx: serialises memory-manager received-number reports
// into fixed-length byte frames for the host UART transmitter.
module mem_report_tx #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter logic [7:0] MSG_ID = 8'h05
) (
    input  logic                             clk,
    input  logic                             n_reset,
    input  logic [ADDR_WIDTH+DATA_WIDTH-1:0] mem_received_num,
    input  logic                             mem_received_valid,
    input  logic                             mem_received_replaced,
    input  logic                             mem_received_overrun,
    output logic                             mem_received_ack,
    output logic [7:0]                       tx_data,
    output logic                             tx_valid,
    input  logic                             tx_ready
);

    localparam int ABYTES = (ADDR_WIDTH + 7) / 8;
    localparam int DBYTES = (DATA_WIDTH + 7) / 8;
    localparam int NF     = ABYTES + DBYTES;
    localparam int NBYTES = 2 + NF;
    localparam int CW     = $clog2(NBYTES);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [0:0]      state;
    logic [CW-1:0]   cnt;
    logic [NF*8-1:0] shadow;
    logic            shadow_repl;
    logic            sticky;
    logic            late;

    logic [NF*8-1:0] field_in;
    logic [7:0]      flags;
    logic [7:0]      nbyte;
    logic            accept;
    logic            last;
    logic            flags_acc;
    int              nidx;

    assign accept    = (state == SEND) && tx_ready;
    assign last      = (cnt == CW'(NBYTES - 1));
    assign flags_acc = accept && (cnt == CW'(1));

    // Zero-extend address and data fields to whole bytes, address on top.
    always_comb begin
        field_in = '0;
        field_in[DATA_WIDTH-1:0] = mem_received_num[DATA_WIDTH-1:0];
        field_in[DBYTES*8 +: ADDR_WIDTH] =
            mem_received_num[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    end

    // Flags byte; a same-cycle overrun is folded in so it is not lost.
    always_comb begin
        flags = {6'b0, sticky | mem_received_overrun, shadow_repl};
    end

    // Byte that follows the one currently on the bus.
    always_comb begin
        nidx  = int'(cnt) + 1;
        nbyte = 8'h00;
        if (nidx == 1) begin
            nbyte = flags;
        end
        for (int b = 0; b < NF; b++) begin
            if (nidx == NF + 1 - b) begin
                nbyte = shadow[b*8 +: 8];
            end
        end
    end

    // Frame FSM: capture in IDLE, shift registered bytes out in SEND.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state            <= IDLE;
            cnt              <= '0;
            shadow           <= '0;
            shadow_repl      <= 1'b0;
            mem_received_ack <= 1'b0;
            tx_valid         <= 1'b0;
            tx_data          <= 8'h00;
        end else begin
            mem_received_ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_received_valid) begin
                        shadow           <= field_in;
                        shadow_repl      <= mem_received_replaced;
                        mem_received_ack <= 1'b1;
                        tx_valid         <= 1'b1;
                        tx_data          <= MSG_ID;
                        cnt              <= '0;
                        state            <= SEND;
                    end
                end
                SEND: begin
                    if (tx_ready) begin
                        if (last) begin
                            tx_valid <= 1'b0;
                            tx_data  <= 8'h00;
                            cnt      <= '0;
                            state    <= IDLE;
                        end else begin
                            tx_data <= nbyte;
                            cnt     <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Sticky overrun; an overrun arriving while the flags byte is already
    // on the bus is remembered in late so the next frame reports it.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            sticky <= 1'b0;
            late   <= 1'b0;
        end else if (flags_acc) begin
            sticky <= mem_received_overrun | late;
            late   <= 1'b0;
        end else begin
            if (mem_received_overrun) begin
                sticky <= 1'b1;
            end
            if (mem_received_overrun && state == SEND && cnt == CW'(1)) begin
                late <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_mem_report_tx.sv
// tb_mem_report_tx: directed scoreboard bench for mem_report_tx,
// default widths plus a 10/31-bit instance.
module tb_mem_report_tx;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;

    logic [39:0] num = '0;
    logic        valid = 1'b0;
    logic        repl = 1'b0;
    logic        ovf = 1'b0;
    logic        ack;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;

    logic [40:0] num2 = '0;
    logic        valid2 = 1'b0;
    logic        repl2 = 1'b0;
    logic        ovf2 = 1'b0;
    logic        ack2;
    logic [7:0]  tx_data2;
    logic        tx_valid2;
    logic        tx_ready2 = 1'b1;

    int errors = 0;
    int checks = 0;
    int nbytes_seen = 0;
    logic [7:0] q[$];
    logic [7:0] q2[$];
    logic [7:0] prev_data = 8'h00;
    logic       prev_stall = 1'b0;

    always #5 clk = ~clk;

    mem_report_tx u_dut (
        .clk                   (clk),
        .n_reset               (n_reset),
        .mem_received_num      (num),
        .mem_received_valid    (valid),
        .mem_received_replaced (repl),
        .mem_received_overrun  (ovf),
        .mem_received_ack      (ack),
        .tx_data               (tx_data),
        .tx_valid              (tx_valid),
        .tx_ready              (tx_ready)
    );

    mem_report_tx #(.ADDR_WIDTH(10), .DATA_WIDTH(31)) u_w (
        .clk                   (clk),
        .n_reset               (n_reset),
        .mem_received_num      (num2),
        .mem_received_valid    (valid2),
        .mem_received_replaced (repl2),
        .mem_received_overrun  (ovf2),
        .mem_received_ack      (ack2),
        .tx_data               (tx_data2),
        .tx_valid              (tx_valid2),
        .tx_ready              (tx_ready2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference frame for the default widths.
    task automatic push_frame(input logic [7:0] a, input logic [31:0] d,
                              input logic r, input logic o);
        q.push_back(8'h05);
        q.push_back({6'b0, o, r});
        q.push_back(a);
        q.push_back(d[31:24]);
        q.push_back(d[23:16]);
        q.push_back(d[15:8]);
        q.push_back(d[7:0]);
    endtask

    // Scoreboard and hold-stability monitor, default instance.
    always @(negedge clk) begin
        if (prev_stall) begin
            chk("hold_valid", tx_valid, 1);
            chk("hold_data", tx_data, prev_data);
        end
        if (tx_valid && tx_ready) begin
            nbytes_seen++;
            if (q.size() == 0) begin
                chk("spurious_byte", tx_data, 32'hFFFF_FFFF);
            end else begin
                chk("byte", tx_data, q.pop_front());
            end
        end
        prev_stall = tx_valid && !tx_ready && n_reset;
        prev_data  = tx_data;
    end

    // Scoreboard for the wide-parameter instance.
    always @(negedge clk) begin
        if (tx_valid2 && tx_ready2) begin
            if (q2.size() == 0) begin
                chk("spurious_byte_w", tx_data2, 32'hFFFF_FFFF);
            end else begin
                chk("byte_w", tx_data2, q2.pop_front());
            end
        end
    end

    // One report with tx_ready high; overrun pulsed in cycle ovf_i.
    task automatic do_frame(input logic [7:0] a, input logic [31:0] d,
                            input logic r, input logic o, input int ovf_i);
        push_frame(a, d, r, o);
        num   = {a, d};
        repl  = r;
        valid = 1'b1;
        step();
        for (int i = 0; i < 7; i++) begin
            ovf = (i == ovf_i);
            if (i == 1) valid = 1'b0;
            @(negedge clk);
            chk("frame_ack", ack, (i == 0));
            chk("frame_valid", tx_valid, 1);
            step();
        end
        ovf = 1'b0;
        @(negedge clk);
        chk("frame_end_valid", tx_valid, 0);
        chk("frame_end_ack", ack, 0);
        step();
    endtask

    initial begin
        int seen;
        repeat (3) step();
        @(negedge clk);
        chk("rst_ack", ack, 0);
        chk("rst_valid", tx_valid, 0);
        chk("rst_data", tx_data, 0);
        step();
        n_reset = 1'b1;
        step();

        // Single report.
        do_frame(8'd4, 32'd1, 1'b0, 1'b0, -1);

        // Replacement report with alternating backpressure.
        push_frame(8'd3, 32'h25C, 1'b1, 1'b0);
        num      = {8'd3, 32'h25C};
        repl     = 1'b1;
        valid    = 1'b1;
        tx_ready = 1'b0;
        step();
        for (int i = 0; i < 13; i++) begin
            tx_ready = (i % 2 == 0);
            if (i == 1) valid = 1'b0;
            @(negedge clk);
            chk("bp_ack", ack, (i == 0));
            chk("bp_valid", tx_valid, 1);
            step();
        end
        tx_ready = 1'b1;
        @(negedge clk);
        chk("bp_end_valid", tx_valid, 0);
        step();

        // Overrun flagging across four frames.
        do_frame(8'h11, 32'h1234_5678, 1'b0, 1'b0, 2);
        do_frame(8'h22, 32'h0000_0042, 1'b1, 1'b1, 1);
        do_frame(8'h33, 32'hDEAD_BEEF, 1'b0, 1'b1, -1);
        do_frame(8'h44, 32'h0000_0007, 1'b0, 1'b0, -1);

        // Second report raised while the first is in byte 3.
        push_frame(8'd1, 32'hAABB_CCDD, 1'b0, 1'b0);
        push_frame(8'd2, 32'd6000, 1'b0, 1'b0);
        num   = {8'd1, 32'hAABB_CCDD};
        repl  = 1'b0;
        valid = 1'b1;
        step();
        for (int i = 0; i < 15; i++) begin
            if (i == 1) valid = 1'b0;
            if (i == 3) begin
                num   = {8'd2, 32'd6000};
                valid = 1'b1;
            end
            if (i == 9) valid = 1'b0;
            @(negedge clk);
            chk("pend_ack", ack, (i == 0 || i == 8));
            chk("pend_valid", tx_valid, (i != 7));
            step();
        end
        @(negedge clk);
        chk("pend_end_valid", tx_valid, 0);
        chk("pend_q_empty", q.size(), 0);
        step();

        // Reset in the middle of a frame, valid held high throughout.
        push_frame(8'd4, 32'd1, 1'b0, 1'b0);
        num   = {8'd4, 32'd1};
        valid = 1'b1;
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("pre_rst_valid", tx_valid, 1);
            step();
        end
        n_reset = 1'b0;
        #1;
        chk("async_rst_valid", tx_valid, 0);
        chk("async_rst_data", tx_data, 0);
        chk("async_rst_ack", ack, 0);
        q.delete();
        seen = nbytes_seen;
        repeat (2) step();
        chk("no_bytes_in_rst", nbytes_seen, seen);
        n_reset = 1'b1;
        do_frame(8'd4, 32'd1, 1'b0, 1'b0, -1);

        // 10-bit address, 31-bit data instance.
        q2.push_back(8'h05);
        q2.push_back(8'h00);
        q2.push_back(8'h03);
        q2.push_back(8'hFF);
        q2.push_back(8'h3C);
        q2.push_back(8'h68);
        q2.push_back(8'h8B);
        q2.push_back(8'hF9);
        num2   = {10'h3FF, 31'h3C68_8BF9};
        valid2 = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            if (i == 1) valid2 = 1'b0;
            @(negedge clk);
            chk("w_ack", ack2, (i == 0));
            chk("w_valid", tx_valid2, 1);
            step();
        end
        @(negedge clk);
        chk("w_end_valid", tx_valid2, 0);
        chk("q_drained", q.size(), 0);
        chk("q2_drained", q2.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
